inta_sequencer: RTL and testbench

Synchronous interrupt-acknowledge sequencer for the 8259-compatible PIC. It converts the priority resolver's one-hot winner into the INT request, then tracks the two 8086-mode INTA pulses. Over that sequence it drives freeze, in-service latch, IRR clear, AEOI, the cascade address lines and the vector byte. It sits between the priority resolver, the ISR/IRR blocks, the cascade pins and the data bus buffer, and is configured from stored ICW values.

---
 rtl/pic_pkg.sv | 21 ++
 rtl/bit_to_num.sv | 17 +
 rtl/inta_sequencer.sv | 151 +++++++++++++++
 tb/tb_inta_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types and helpers for the 8259-compatible PIC blocks.
package pic_pkg;

    // Interrupt-acknowledge sequence states.
    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        ACK1,
        GAP,
        ACK2
    } seq_state_t;

    // IR level, 0..7.
    typedef logic [2:0] level_t;

    // Expand an IR level to its one-hot IRR/ISR bit.
    function automatic logic [7:0] num_to_onehot(input level_t num);
        return 8'b0000_0001 << num;
    endfunction

endpackage

// File: rtl/bit_to_num.sv
// 8-to-3 priority encoder: the lowest set bit (highest IR priority) wins.
module bit_to_num (
    input  logic [7:0] bits,
    output logic [2:0] num,
    output logic       valid
);

    // Scan from IR7 down so the lowest set index is the last to assign.
    always_comb begin
        num   = 3'd0;
        valid = |bits;
        for (int i = 7; i >= 0; i--) begin
            if (bits[i]) num = 3'(i);
        end
    end

endmodule

// File: rtl/inta_sequencer.sv
// Interrupt request / two-pulse INTA acknowledge sequencer.
module inta_sequencer
    import pic_pkg::*;
#(
    parameter int SPURIOUS_LEVEL = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       init_reset,
    input  logic [7:0] interrupt_id,
    input  logic [7:0] icw2_vector,
    input  logic       sngl,
    input  logic       sp_en,
    input  logic       aeoi,
    input  logic [7:0] icw3,
    input  logic [2:0] cas_in,
    input  logic       inta_n,
    output logic       int_out,
    output logic       freeze,
    output logic       latch_in_service,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] end_of_interrupt,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic [2:0] cas_out,
    output logic       cas_oe
);

    seq_state_t state, state_d;
    level_t     level, level_d;
    logic       inta_q;
    logic       int_d, freeze_d, lis_d, data_oe_d, cas_oe_d;
    logic [7:0] clr_d, eoi_d, data_d;
    logic [2:0] cas_d;
    level_t     enc_num;
    logic       enc_valid;
    level_t     cap_level;
    logic       fall, rise;

    bit_to_num u_enc (
        .bits  (interrupt_id),
        .num   (enc_num),
        .valid (enc_valid)
    );

    assign fall      = inta_q & ~inta_n;
    assign rise      = ~inta_q & inta_n;
    assign cap_level = enc_valid ? enc_num : level_t'(SPURIOUS_LEVEL);

    // INTA edge-detect register; init_reset does not touch the strobe history.
    always_ff @(posedge clk) begin
        if (!rst_n) inta_q <= 1'b1;
        else        inta_q <= inta_n;
    end

    // Next-state and next-output decode; pulse outputs default to 0.
    always_comb begin
        state_d   = state;
        level_d   = level;
        int_d     = int_out;
        freeze_d  = freeze;
        lis_d     = 1'b0;
        clr_d     = 8'h00;
        eoi_d     = 8'h00;
        data_oe_d = data_oe;
        data_d    = data_out;
        cas_d     = cas_out;
        cas_oe_d  = cas_oe;
        unique case (state)
            IDLE: begin
                if (interrupt_id != 8'h00) begin
                    state_d = ARMED;
                    int_d   = 1'b1;
                end
            end
            ARMED: begin
                if (fall) begin
                    state_d  = ACK1;
                    level_d  = cap_level;
                    freeze_d = 1'b1;
                    lis_d    = 1'b1;
                    clr_d    = num_to_onehot(cap_level);
                    // Master steers a cascaded slave for the whole acknowledge.
                    if (!sngl && sp_en && icw3[cap_level]) begin
                        cas_d    = cap_level;
                        cas_oe_d = 1'b1;
                    end
                end else if (interrupt_id == 8'h00) begin
                    state_d = IDLE;
                    int_d   = 1'b0;
                end
            end
            ACK1: begin
                if (rise) state_d = GAP;
            end
            GAP: begin
                if (fall) begin
                    state_d = ACK2;
                    if (sngl || (sp_en ? !icw3[level] : (cas_in == icw3[2:0]))) begin
                        data_oe_d = 1'b1;
                        data_d    = {icw2_vector[7:3], level};
                    end
                end
            end
            ACK2: begin
                if (rise) begin
                    state_d   = IDLE;
                    int_d     = 1'b0;
                    freeze_d  = 1'b0;
                    data_oe_d = 1'b0;
                    data_d    = 8'h00;
                    cas_d     = 3'd0;
                    cas_oe_d  = 1'b0;
                    // An unaddressed slave (data_oe low) must not retire its ISR bit.
                    if (aeoi && (sngl || sp_en || data_oe)) eoi_d = num_to_onehot(level);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; init_reset aborts like a reset.
    always_ff @(posedge clk) begin
        if (!rst_n || init_reset) begin
            state                   <= IDLE;
            level                   <= 3'd0;
            int_out                 <= 1'b0;
            freeze                  <= 1'b0;
            latch_in_service        <= 1'b0;
            clear_interrupt_request <= 8'h00;
            end_of_interrupt        <= 8'h00;
            data_out                <= 8'h00;
            data_oe                 <= 1'b0;
            cas_out                 <= 3'd0;
            cas_oe                  <= 1'b0;
        end else begin
            state                   <= state_d;
            level                   <= level_d;
            int_out                 <= int_d;
            freeze                  <= freeze_d;
            latch_in_service        <= lis_d;
            clear_interrupt_request <= clr_d;
            end_of_interrupt        <= eoi_d;
            data_out                <= data_d;
            data_oe                 <= data_oe_d;
            cas_out                 <= cas_d;
            cas_oe                  <= cas_oe_d;
        end
    end

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer with a pulse-counting reference model.
module tb_inta_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       init_reset = 1'b0;
    logic [7:0] interrupt_id = 8'h00;
    logic [7:0] icw2_vector = 8'h40;
    logic       sngl = 1'b1;
    logic       sp_en = 1'b1;
    logic       aeoi = 1'b1;
    logic [7:0] icw3 = 8'h00;
    logic [2:0] cas_in = 3'd0;
    logic       inta_n = 1'b1;
    logic       int_out, freeze, latch_in_service, data_oe, cas_oe;
    logic [7:0] clear_interrupt_request, end_of_interrupt, data_out;
    logic [2:0] cas_out;

    int checks = 0;
    int passed = 0;

    inta_sequencer dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .init_reset              (init_reset),
        .interrupt_id            (interrupt_id),
        .icw2_vector             (icw2_vector),
        .sngl                    (sngl),
        .sp_en                   (sp_en),
        .aeoi                    (aeoi),
        .icw3                    (icw3),
        .cas_in                  (cas_in),
        .inta_n                  (inta_n),
        .int_out                 (int_out),
        .freeze                  (freeze),
        .latch_in_service        (latch_in_service),
        .clear_interrupt_request (clear_interrupt_request),
        .end_of_interrupt        (end_of_interrupt),
        .data_out                (data_out),
        .data_oe                 (data_oe),
        .cas_out                 (cas_out),
        .cas_oe                  (cas_oe)
    );

    always #5 clk = ~clk;

    // Reference model: a request is "busy" from arming until the second INTA
    // pulse ends; nf/nr count accepted falls/rises within that request.
    logic       m_busy = 1'b0, m_freeze = 1'b0, m_lis = 1'b0, m_doe = 1'b0;
    logic       m_casoe = 1'b0, m_resp = 1'b0, m_prev = 1'b1;
    logic [7:0] m_clr = 8'h00, m_eoi = 8'h00, m_dout = 8'h00;
    logic [2:0] m_cas = 3'd0, m_lvl = 3'd0;
    int         nf = 0, nr = 0;

    always @(posedge clk) begin : model
        logic fall, rise;
        fall  = m_prev && !inta_n;
        rise  = !m_prev && inta_n;
        m_lis = 1'b0;
        m_clr = 8'h00;
        m_eoi = 8'h00;
        if (!rst_n || init_reset) begin
            m_busy = 1'b0; m_freeze = 1'b0; m_doe = 1'b0; m_dout = 8'h00;
            m_cas = 3'd0; m_casoe = 1'b0; m_lvl = 3'd0; nf = 0; nr = 0;
            m_prev = rst_n ? inta_n : 1'b1;
        end else begin
            m_prev = inta_n;
            if (!m_busy) begin
                if (interrupt_id != 8'h00) begin
                    m_busy = 1'b1; nf = 0; nr = 0;
                end
            end else if (fall && nf == nr) begin
                nf++;
                if (nf == 1) begin
                    m_lvl = 3'd7;
                    for (int i = 7; i >= 0; i--) if (interrupt_id[i]) m_lvl = 3'(i);
                    m_freeze = 1'b1;
                    m_lis    = 1'b1;
                    m_clr    = 8'h01 << m_lvl;
                    if (!sngl && sp_en && icw3[m_lvl]) begin
                        m_cas = m_lvl; m_casoe = 1'b1;
                    end
                end else begin
                    if (sngl)       m_resp = 1'b1;
                    else if (sp_en) m_resp = !icw3[m_lvl];
                    else            m_resp = (cas_in == icw3[2:0]);
                    if (m_resp) begin
                        m_doe = 1'b1; m_dout = {icw2_vector[7:3], m_lvl};
                    end
                end
            end else if (rise && nf == nr + 1) begin
                nr++;
                if (nr == 2) begin
                    if (aeoi && (sngl || sp_en || m_resp)) m_eoi = 8'h01 << m_lvl;
                    m_busy = 1'b0; m_freeze = 1'b0; m_doe = 1'b0; m_dout = 8'h00;
                    m_cas = 3'd0; m_casoe = 1'b0; nf = 0; nr = 0;
                end
            end else if (nf == 0 && interrupt_id == 8'h00) begin
                m_busy = 1'b0;
            end
        end
    end

    function automatic logic [31:0] dut_vec();
        return {int_out, freeze, latch_in_service, clear_interrupt_request,
                end_of_interrupt, data_out, data_oe, cas_out, cas_oe};
    endfunction

    function automatic logic [31:0] mdl_vec();
        return {m_busy, m_freeze, m_lis, m_clr, m_eoi, m_dout, m_doe, m_cas, m_casoe};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // Advance n clocks, comparing the full output set to the model after each edge.
    task automatic cyc(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
            chk("model", dut_vec(), mdl_vec());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cyc(3);
        chk("reset_all_zero", dut_vec(), 32'h0);
        rst_n = 1'b1;
        cyc(2);

        // Single mode, vector base 0x40, IR3.
        interrupt_id = 8'h08; cyc();
        chk("int_latency", 32'(int_out), 32'd1);
        inta_n = 1'b0; cyc();
        chk("ack1_lis", 32'(latch_in_service), 32'd1);
        chk("ack1_clr", 32'(clear_interrupt_request), 32'h08);
        interrupt_id = 8'h00; cyc();
        chk("lis_one_cycle", 32'(latch_in_service), 32'd0);
        inta_n = 1'b1; cyc(2);
        inta_n = 1'b0; cyc();
        chk("vector_43", {23'd0, data_oe, data_out}, {23'd0, 1'b1, 8'h43});
        inta_n = 1'b1; cyc();
        chk("aeoi_08", {23'd0, data_oe, end_of_interrupt}, {23'd0, 1'b0, 8'h08});
        cyc(2);

        // Request withdrawn before INTA, then a spurious acknowledge.
        aeoi = 1'b0;
        interrupt_id = 8'h04; cyc();
        interrupt_id = 8'h00; cyc();
        chk("withdraw_int", 32'(int_out), 32'd0);
        interrupt_id = 8'h02; cyc();
        interrupt_id = 8'h00; inta_n = 1'b0; cyc();
        chk("spurious_clr", 32'(clear_interrupt_request), 32'h80);
        inta_n = 1'b1; cyc();
        inta_n = 1'b0; cyc();
        chk("spurious_vec", 32'(data_out), 32'h47);
        inta_n = 1'b1; cyc(2);

        // Master with a slave on IR2.
        aeoi = 1'b1; sngl = 1'b0; sp_en = 1'b1; icw3 = 8'h04;
        interrupt_id = 8'h04; cyc();
        inta_n = 1'b0; cyc();
        interrupt_id = 8'h00;
        chk("master_cas", {28'd0, cas_out, cas_oe}, {28'd0, 3'd2, 1'b1});
        inta_n = 1'b1; cyc();
        inta_n = 1'b0; cyc();
        chk("master_no_doe", {28'd0, data_oe, cas_oe, cas_out[1:0]}, {28'd0, 1'b0, 1'b1, 2'd2});
        inta_n = 1'b1; cyc();
        chk("master_cas_off", 32'(cas_oe), 32'd0);
        cyc(2);

        // Slave with ID 3, addressed.
        sp_en = 1'b0; icw3 = 8'h03; cas_in = 3'd3; icw2_vector = 8'h88;
        interrupt_id = 8'h01; cyc();
        inta_n = 1'b0; cyc();
        interrupt_id = 8'h00;
        inta_n = 1'b1; cyc();
        inta_n = 1'b0; cyc();
        chk("slave_hit_vec", {23'd0, data_oe, data_out}, {23'd0, 1'b1, 8'h88});
        inta_n = 1'b1; cyc();
        chk("slave_hit_eoi", 32'(end_of_interrupt), 32'h01);
        cyc(2);

        // Slave not addressed.
        cas_in = 3'd5;
        interrupt_id = 8'h01; cyc();
        inta_n = 1'b0; cyc();
        interrupt_id = 8'h00;
        inta_n = 1'b1; cyc();
        inta_n = 1'b0; cyc();
        chk("slave_miss_doe", 32'(data_oe), 32'd0);
        inta_n = 1'b1; cyc();
        chk("slave_miss_eoi", 32'(end_of_interrupt), 32'h00);
        cyc(2);

        // init_reset while in GAP.
        sngl = 1'b1; icw2_vector = 8'h40;
        interrupt_id = 8'h08; cyc();
        inta_n = 1'b0; cyc();
        interrupt_id = 8'h00;
        inta_n = 1'b1; cyc();
        init_reset = 1'b1; cyc();
        chk("init_all_zero", dut_vec(), 32'h0);
        init_reset = 1'b0;
        inta_n = 1'b0; cyc();
        chk("init_no_doe", {30'd0, data_oe, int_out}, 32'd0);
        inta_n = 1'b1; cyc(2);

        // rst_n during ACK2.
        interrupt_id = 8'h08; cyc();
        inta_n = 1'b0; cyc();
        interrupt_id = 8'h00;
        inta_n = 1'b1; cyc();
        inta_n = 1'b0; cyc();
        chk("ack2_doe", {30'd0, freeze, data_oe}, {30'd0, 1'b1, 1'b1});
        rst_n = 1'b0; cyc();
        chk("rst_ack2", {30'd0, freeze, data_oe}, 32'd0);
        rst_n = 1'b1; inta_n = 1'b1; cyc(3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
